// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT sequencing controller.
package ntt_pkg;

  localparam int NTT_N          = 1024;
  localparam int NTT_LOGN       = 10;
  localparam int NTT_BF_LATENCY = 6;

  typedef logic [NTT_LOGN-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Maps (stage, butterfly counter) to the Cooley-Tukey operand pair and twiddle index.
module ntt_addr_gen import ntt_pkg::*; #(
  parameter int LOGN = NTT_LOGN
) (
  input  logic [LOGN-1:0] s,
  input  logic [LOGN-2:0] c,
  output logic [LOGN-1:0] a,
  output logic [LOGN-1:0] b,
  output logic [LOGN-1:0] omega_idx
);

  localparam logic [LOGN-1:0] ONE     = {{(LOGN-1){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] MSB     = {1'b1, {(LOGN-1){1'b0}}};
  localparam logic [LOGN-1:0] LOGN_V  = LOGN'(LOGN);
  localparam logic [LOGN-1:0] LOGN_M1 = LOGN'(LOGN - 1);

  logic [LOGN-1:0] cx;
  logic [LOGN-1:0] half;
  logic [LOGN-1:0] j;
  logic [LOGN-1:0] k;

  // j selects the butterfly group, k the offset inside it; a spreads j above the half-span.
  always_comb begin
    cx        = {1'b0, c};
    half      = MSB >> s;
    j         = cx >> (LOGN_M1 - s);
    k         = cx & (half - ONE);
    a         = (j << (LOGN_V - s)) | k;
    b         = a | half;
    omega_idx = (ONE << s) | j;
  end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT stage sequencer: issues one butterfly per cycle and drains the pipeline between stages.
module ntt_ctrl import ntt_pkg::*; #(
  parameter int N          = NTT_N,
  parameter int LOGN       = NTT_LOGN,
  parameter int BF_LATENCY = NTT_BF_LATENCY
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            inverse,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN:0]   omega_addr,
  output logic            bf_is_valid,
  output logic            bf_en,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [LOGN-1:0] stage
);

  localparam int              DL     = BF_LATENCY + 1;
  localparam logic [LOGN-2:0] C_LAST = (LOGN-1)'(N / 2 - 1);
  localparam logic [LOGN-2:0] C_ONE  = {{(LOGN-2){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] S_ONE  = {{(LOGN-1){1'b0}}, 1'b1};
  localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);

  state_e          state_q;
  logic [LOGN-1:0] s_q;
  logic [LOGN-2:0] c_q;
  logic            inv_q;
  logic [DL-1:0]   vld_q;
  logic [LOGN-1:0] dl_a_q [DL];
  logic [LOGN-1:0] dl_b_q [DL];
  logic [LOGN-1:0] a;
  logic [LOGN-1:0] b;
  logic [LOGN-1:0] om_idx;
  logic            last_wr;

  ntt_addr_gen #(.LOGN(LOGN)) u_addr (
    .s         (s_q),
    .c         (c_q),
    .a         (a),
    .b         (b),
    .omega_idx (om_idx)
  );

  assign rd_en       = (state_q == ISSUE);
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign bf_en       = busy;
  assign done        = (state_q == FIN);
  assign rd_addr_a   = rd_en ? a : '0;
  assign rd_addr_b   = rd_en ? b : '0;
  assign omega_addr  = rd_en ? {inv_q, om_idx} : '0;
  assign bf_is_valid = vld_q[0];
  assign wr_en       = vld_q[DL-1];
  assign wr_addr_a   = dl_a_q[DL-1];
  assign wr_addr_b   = dl_b_q[DL-1];
  assign stage       = s_q;

  // Last write-back of a stage: output valid with nothing else left in flight.
  assign last_wr = wr_en && (vld_q[DL-2:0] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DL; i++) begin
        dl_a_q[i] <= '0;
        dl_b_q[i] <= '0;
      end
    end else begin
      vld_q     <= {vld_q[DL-2:0], rd_en};
      dl_a_q[0] <= rd_addr_a;
      dl_b_q[0] <= rd_addr_b;
      for (int unsigned i = 1; i < DL; i++) begin
        dl_a_q[i] <= dl_a_q[i-1];
        dl_b_q[i] <= dl_b_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            inv_q   <= inverse;
            s_q     <= '0;
            c_q     <= '0;
          end
        end
        ISSUE: begin
          c_q <= c_q + C_ONE;
          if (c_q == C_LAST) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_wr) begin
            if (s_q == S_LAST) begin
              state_q <= FIN;
            end else begin
              state_q <= ISSUE;
              s_q     <= s_q + S_ONE;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          s_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl with a behavioural RAM/ROM/butterfly and a direct-evaluation NTT reference.
module tb_ntt_ctrl;
  import ntt_pkg::*;

  localparam int N       = NTT_N;
  localparam int LOGN    = NTT_LOGN;
  localparam int BFL     = NTT_BF_LATENCY;
  localparam int P       = N / 2 + BFL + 1;
  localparam int RUN_LEN = LOGN * P + 1;
  localparam int Q       = 12289;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            inverse = 1'b0;
  logic            busy, done, rd_en, bf_is_valid, bf_en, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [LOGN:0]   omega_addr;

  ntt_ctrl #(.N(N), .LOGN(LOGN), .BF_LATENCY(BFL)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .inverse     (inverse),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .omega_addr  (omega_addr),
    .bf_is_valid (bf_is_valid),
    .bf_en       (bf_en),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b),
    .stage       (stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int om;
    int cyc;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  active  = 1'b0;
  int  t0      = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int brv(input int v);
    int r = 0;
    for (int i = 0; i < LOGN; i++) r |= ((v >> i) & 1) << (LOGN - 1 - i);
    return r;
  endfunction

  function automatic longint powmod(input longint g, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * g) % Q;
    return r;
  endfunction

  // Behavioural coefficient RAM, twiddle ROM and 6-cycle butterfly
  int unsigned mem  [N];
  int unsigned xin  [N];
  int unsigned rom  [2*N];
  longint      pw   [2*N];
  int unsigned ra, rb, rw;
  int unsigned pa [BFL];
  int unsigned pb [BFL];
  bit          load_req = 1'b0;

  function automatic int unsigned bf_out(input int unsigned x, input int unsigned y,
                                         input int unsigned w, input bit lower);
    longint t = (longint'(w) * longint'(y)) % Q;
    return lower ? int'((longint'(x) + Q - t) % Q) : int'((longint'(x) + t) % Q);
  endfunction

  always @(posedge clk) begin
    if (load_req) for (int i = 0; i < N; i++) mem[i] <= xin[i];
    if (rd_en) begin
      ra <= mem[rd_addr_a];
      rb <= mem[rd_addr_b];
      rw <= rom[omega_addr];
    end
    pa[0] <= bf_out(ra, rb, rw, 1'b0);
    pb[0] <= bf_out(ra, rb, rw, 1'b1);
    for (int k = 1; k < BFL; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
    if (wr_en) begin
      mem[wr_addr_a] <= pa[BFL-1];
      mem[wr_addr_b] <= pb[BFL-1];
    end
  end

  // Expected schedule: stage s handles 2^s groups of span 2*half, back to back from t0+1+s*P
  function automatic void push_run(input bit inv);
    ev_t e;
    int  idx, half;
    for (int s = 0; s < LOGN; s++) begin
      half = N / (2 ** (s + 1));
      idx  = 0;
      for (int g = 0; g < 2 ** s; g++) begin
        for (int k = 0; k < half; k++) begin
          e.a   = 2 * half * g + k;
          e.b   = e.a + half;
          e.om  = (inv ? N : 0) + 2 ** s + g;
          e.cyc = t0 + 1 + s * P + idx;
          idx++;
          rdq.push_back(e);
          e.cyc += BFL + 1;
          wrq.push_back(e);
        end
      end
    end
  endfunction

  function automatic bit in_rd_win(input int d);
    return d >= 0 && d < LOGN * P && (d % P) < N / 2;
  endfunction

  always @(negedge clk) begin
    int  d;
    bit  busy_x;
    ev_t e;
    if (!active) begin
      chk("idle_ctrl", {busy, done, rd_en, bf_is_valid, bf_en, wr_en, stage}, 0);
      chk("idle_rd", {rd_addr_a, rd_addr_b, omega_addr}, 0);
      chk("idle_wr", {wr_addr_a, wr_addr_b}, 0);
    end else begin
      d      = cyc - t0 - 1;
      busy_x = d >= 0 && d < LOGN * P;
      chk("busy", busy, busy_x);
      chk("bf_en", bf_en, busy_x);
      chk("rd_en", rd_en, in_rd_win(d));
      chk("bf_is_valid", bf_is_valid, in_rd_win(d - 1));
      chk("done", done, cyc == t0 + RUN_LEN);
      if (busy_x) chk("stage", stage, d / P);
      if (cyc == t0 + RUN_LEN) active = 1'b0;
    end
    if (rd_en) begin
      if (rdq.size() == 0) chk("rd_unexpected", rd_en, 0);
      else begin
        e = rdq.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_addr_a", rd_addr_a, e.a);
        chk("rd_addr_b", rd_addr_b, e.b);
        chk("omega_addr", omega_addr, e.om);
      end
    end
    if (wr_en) begin
      if (wrq.size() == 0) chk("wr_unexpected", wr_en, 0);
      else begin
        e = wrq.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr_a", wr_addr_a, e.a);
        chk("wr_addr_b", wr_addr_b, e.b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int i = 0; i < N; i++) xin[i] = $urandom_range(Q - 1);
    step();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic launch(input bit inv);
    step();
    start   = 1'b1;
    inverse = inv;
    t0      = cyc;
    push_run(inv);
    active  = 1'b1;
    step();
    start   = 1'b0;
    inverse = ~inv;
  endtask

  task automatic wait_done(input bit pulses);
    while (active && cyc <= t0 + RUN_LEN + 20) begin
      start   = pulses && (cyc == t0 + 100 || cyc == t0 + 2000);
      inverse = 1'($urandom);
      step();
    end
    start = 1'b0;
    chk("run_finished", active, 0);
    active = 1'b0;
    chk("rd_left", rdq.size(), 0);
    chk("wr_left", wrq.size(), 0);
    rdq.delete();
    wrq.delete();
    repeat (3) step();
  endtask

  // Negacyclic NTT in bit-reversed order: out[i] = x(psi^(2*brv(i)+1))
  task automatic check_data();
    longint acc;
    int     e0;
    for (int i = 0; i < N; i++) begin
      e0  = 2 * brv(i) + 1;
      acc = 0;
      for (int m = 0; m < N; m++) acc = (acc + longint'(xin[m]) * pw[(e0 * m) % (2 * N)]) % Q;
      chk($sformatf("coef[%0d]", i), mem[i], acc);
    end
  endtask

  initial begin
    longint psi = 0;
    for (int g = 2; g < Q && psi == 0; g++) if (powmod(g, N) == Q - 1) psi = g;
    pw[0] = 1;
    for (int e = 1; e < 2 * N; e++) pw[e] = (pw[e-1] * psi) % Q;
    for (int k = 0; k < N; k++) begin
      rom[k]     = int'(pw[brv(k)]);
      rom[N + k] = int'(pw[(2 * N - brv(k)) % (2 * N)]);
    end

    repeat (3) step();
    reset = 1'b1;
    repeat (4) step();

    // forward transform with data check; extra starts mid-run must be ignored
    load_data();
    launch(1'b0);
    wait_done(1'b1);
    check_data();

    // inverse table select, addressing only
    launch(1'b1);
    wait_done(1'b0);

    // reset in the middle of stage 3 issue
    launch(1'b0);
    while (cyc < t0 + 1 + 3 * P + 100) step();
    reset  = 1'b0;
    active = 1'b0;
    rdq.delete();
    wrq.delete();
    repeat (3) step();
    reset = 1'b1;
    repeat (40) step();

    // clean restart after reset
    load_data();
    launch(1'b0);
    wait_done(1'b0);
    check_data();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
